// File: rtl/commit_tracker.sv
// In-order commit/retire tracker: allocates issue numbers, gathers out-of-order
// scalar and per-lane completions, and retires entries strictly in issue order.
module commit_tracker #(
  parameter int NUM_ENTRY = 8,
  parameter int WIDTH_NO  = $clog2(NUM_ENTRY),
  parameter int NUM_LANE  = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         I_Issue_Req,
  input  logic [NUM_LANE-1:0]          I_Issue_Lanes,
  output logic                         O_Issue_Grant,
  output logic [WIDTH_NO-1:0]          O_Issue_No,
  input  logic                         I_Commit_S,
  input  logic [WIDTH_NO-1:0]          I_Commit_S_No,
  input  logic [NUM_LANE-1:0]          I_Commit_V,
  input  logic [NUM_LANE*WIDTH_NO-1:0] I_Commit_V_No,
  output logic                         O_Retire,
  output logic [WIDTH_NO-1:0]          O_Retire_No,
  output logic                         O_Full,
  output logic                         O_Empty,
  output logic [WIDTH_NO:0]            O_Count,
  output logic                         O_Err
);

  localparam logic [WIDTH_NO:0] FULL_CNT = (WIDTH_NO+1)'(NUM_ENTRY);

  logic [NUM_ENTRY-1:0] r_v;
  logic [NUM_ENTRY-1:0] r_commit;
  logic [NUM_LANE-1:0]  r_enLane   [NUM_ENTRY];
  logic [NUM_LANE-1:0]  r_enCommit [NUM_ENTRY];
  logic [WIDTH_NO-1:0]  r_head;
  logic [WIDTH_NO-1:0]  r_tail;
  logic [WIDTH_NO:0]    r_count;
  logic                 r_retire;
  logic [WIDTH_NO-1:0]  r_retireNo;
  logic                 r_err;

  logic                 w_full;
  logic                 w_grant;
  logic                 w_headComplete;
  logic                 w_scalarOk;
  logic [NUM_LANE-1:0]  w_laneOk;
  logic [WIDTH_NO-1:0]  w_laneNo [NUM_LANE];
  logic                 w_err;

  assign w_full  = (r_count == FULL_CNT);
  assign w_grant = I_Issue_Req & ~w_full;

  // A vector entry is complete once every enabled lane has reported back.
  assign w_headComplete = r_v[r_head] &
                          ((r_enLane[r_head] == '0) ? r_commit[r_head]
                                                    : (r_enCommit[r_head] == r_enLane[r_head]));

  assign w_scalarOk = r_v[I_Commit_S_No] & (r_enLane[I_Commit_S_No] == '0) & ~r_commit[I_Commit_S_No];

  for (genvar l = 0; l < NUM_LANE; l++) begin : g_lane
    assign w_laneNo[l] = I_Commit_V_No[l*WIDTH_NO +: WIDTH_NO];
    assign w_laneOk[l] = r_v[w_laneNo[l]] & r_enLane[w_laneNo[l]][l] & ~r_enCommit[w_laneNo[l]][l];
  end

  assign w_err = (I_Commit_S & ~w_scalarOk) | (|(I_Commit_V & ~w_laneOk));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_v        <= '0;
      r_commit   <= '0;
      for (int e = 0; e < NUM_ENTRY; e++) begin
        r_enLane[e]   <= '0;
        r_enCommit[e] <= '0;
      end
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_retire   <= 1'b0;
      r_retireNo <= '0;
      r_err      <= 1'b0;
    end else begin
      if (I_Commit_S && w_scalarOk)
        r_commit[I_Commit_S_No] <= 1'b1;
      for (int l = 0; l < NUM_LANE; l++) begin
        if (I_Commit_V[l] && w_laneOk[l])
          r_enCommit[w_laneNo[l]][l] <= 1'b1;
      end
      // Tail and head only coincide when full (no grant) or empty (head invalid).
      if (w_grant) begin
        r_v[r_tail]        <= 1'b1;
        r_commit[r_tail]   <= 1'b0;
        r_enLane[r_tail]   <= I_Issue_Lanes;
        r_enCommit[r_tail] <= '0;
        r_tail             <= r_tail + 1'b1;
      end
      if (w_headComplete) begin
        r_v[r_head]        <= 1'b0;
        r_commit[r_head]   <= 1'b0;
        r_enLane[r_head]   <= '0;
        r_enCommit[r_head] <= '0;
        r_head             <= r_head + 1'b1;
        r_retireNo         <= r_head;
      end
      r_retire <= w_headComplete;
      r_count  <= r_count + (WIDTH_NO+1)'(w_grant) - (WIDTH_NO+1)'(w_headComplete);
      r_err    <= r_err | w_err;
    end
  end

  assign O_Issue_Grant = w_grant;
  assign O_Issue_No    = r_tail;
  assign O_Retire      = r_retire;
  assign O_Retire_No   = r_retireNo;
  assign O_Full        = w_full;
  assign O_Empty       = (r_count == '0);
  assign O_Count       = r_count;
  assign O_Err         = r_err;

endmodule
